// File: rtl/adma_desc_engine_if.sv
// Descriptor-read and transfer-command bus between the ADMA2 descriptor engine
// (master) and the system-memory port / data mover (slave).
interface adma_desc_engine_if #(
    parameter int DESC_AW = 32
);
    logic               mem_req;
    logic [DESC_AW-1:0] mem_addr;
    logic               mem_ack;
    logic [63:0]        mem_rdata;

    logic               xfer_valid;
    logic               xfer_ready;
    logic [DESC_AW-1:0] xfer_addr;
    logic [16:0]        xfer_len;
    logic               xfer_dir;
    logic               xfer_done;

    modport master (
        output mem_req, mem_addr, xfer_valid, xfer_addr, xfer_len, xfer_dir,
        input  mem_ack, mem_rdata, xfer_ready, xfer_done
    );

    modport slave (
        input  mem_req, mem_addr, xfer_valid, xfer_addr, xfer_len, xfer_dir,
        output mem_ack, mem_rdata, xfer_ready, xfer_done
    );
endinterface

// File: rtl/adma_desc_engine.sv
// ADMA2 descriptor walker: fetches 64-bit descriptors, issues TRAN commands, reports status.
// Optional ADMA_LINK_GUARD_EN bounds consecutive LINK/NOP descriptors to LINK_GUARD_MAX.
module adma_desc_engine #(
    parameter int DESC_AW = 32
`ifdef ADMA_LINK_GUARD_EN
    ,
    parameter int LINK_GUARD_MAX = 16
`endif
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               command_reg_write,
    input  logic               command_reg_continue,
    input  logic               STOP,
    input  logic               direction,
    input  logic [DESC_AW-1:0] start_address,
    adma_desc_engine_if.master bus,
    output logic               busy,
    output logic               paused,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_state,
    output logic               int_pulse
);
    // State codes double as the err_state encoding.
    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_FDS  = 2'b01;
    localparam logic [1:0] ST_CADR = 2'b10;
    localparam logic [1:0] ST_TFR  = 2'b11;

    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    logic [1:0]         r_state;
    logic [DESC_AW-1:0] r_desc_ptr;
    logic [63:0]        r_desc;
    logic               r_dir;
    logic               r_hs_done;
    logic               r_busy;
    logic               r_paused;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_state;
    logic               r_int_pulse;

    logic               w_valid;
    logic               w_end;
    logic               w_int;
    logic [1:0]         w_act;
    logic [15:0]        w_len;
    logic [DESC_AW-1:0] w_addr;
    logic               w_is_tran;
    logic               w_is_link;
    logic               w_cadr_err;
    logic               w_guard_err;
    logic               w_xfer_valid;
    logic               w_complete;
    logic               w_unused;

    assign w_valid   = r_desc[0];
    assign w_end     = r_desc[1];
    assign w_int     = r_desc[2];
    assign w_act     = r_desc[5:4];
    assign w_len     = r_desc[31:16];
    assign w_addr    = r_desc[32 +: DESC_AW];
    assign w_unused  = ^{r_desc[15:6], r_desc[3]};
    assign w_is_tran = (w_act == ACT_TRAN);
    assign w_is_link = (w_act == ACT_LINK);

    assign w_cadr_err = !w_valid
                      || (w_is_link && (w_addr[2:0] != 3'b000))
                      || (w_is_tran && (w_addr[1:0] != 2'b00));

`ifdef ADMA_LINK_GUARD_EN
    localparam int GW = $clog2(LINK_GUARD_MAX + 1);

    logic [GW-1:0] r_guard_cnt;

    // The descriptor that would make the run LINK_GUARD_MAX long is the one that errors.
    assign w_guard_err = !w_is_tran && (r_guard_cnt == GW'(LINK_GUARD_MAX - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_guard_cnt <= '0;
        end else if (r_state == ST_STOP && command_reg_write) begin
            r_guard_cnt <= '0;
        end else if (r_state == ST_CADR && !w_cadr_err) begin
            r_guard_cnt <= w_is_tran ? '0 : r_guard_cnt + GW'(1);
        end
    end
`else
    assign w_guard_err = 1'b0;
`endif

    assign w_xfer_valid = (r_state == ST_TFR) && !r_hs_done;
    assign w_complete   = ((r_state == ST_CADR) && !w_cadr_err && !w_guard_err && !w_is_tran)
                        || ((r_state == ST_TFR) && r_hs_done && bus.xfer_done);

    // Requests derive from the async-reset state, so they drop the moment RESET falls.
    assign bus.mem_req    = (r_state == ST_FDS);
    assign bus.mem_addr   = r_desc_ptr;
    assign bus.xfer_valid = w_xfer_valid;
    assign bus.xfer_addr  = w_xfer_valid ? w_addr : '0;
    assign bus.xfer_dir   = w_xfer_valid & r_dir;
    assign bus.xfer_len   = !w_xfer_valid    ? 17'd0 :
                            (w_len == 16'd0) ? 17'h10000 : {1'b0, w_len};

    assign busy      = r_busy;
    assign paused    = r_paused;
    assign done      = r_done;
    assign error     = r_error;
    assign err_state = r_err_state;
    assign int_pulse = r_int_pulse;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the completion block below overrides the case on purpose.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_STOP;
            r_desc_ptr  <= '0;
            r_desc      <= '0;
            r_dir       <= 1'b0;
            r_hs_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_paused    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_state <= 2'b00;
            r_int_pulse <= 1'b0;
        end else begin
            r_int_pulse <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    if (command_reg_write) begin
                        r_desc_ptr  <= start_address;
                        r_dir       <= direction;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_state <= 2'b00;
                        r_paused    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_FDS;
                    end else if (command_reg_continue && r_paused) begin
                        r_paused <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_FDS;
                    end
                end
                ST_FDS: begin
                    if (bus.mem_ack) begin
                        r_desc  <= bus.mem_rdata;
                        r_state <= ST_CADR;
                    end
                end
                ST_CADR: begin
                    if (w_cadr_err || w_guard_err) begin
                        r_error     <= 1'b1;
                        r_err_state <= ST_CADR;
                        r_busy      <= 1'b0;
                        r_state     <= ST_STOP;
                    end else if (w_is_tran) begin
                        r_hs_done <= 1'b0;
                        r_state   <= ST_TFR;
                    end else if (w_is_link) begin
                        r_desc_ptr <= w_addr;
                    end else begin
                        r_desc_ptr <= r_desc_ptr + DESC_AW'(8);
                    end
                end
                ST_TFR: begin
                    if (!r_hs_done) begin
                        if (bus.xfer_ready) begin
                            r_hs_done <= 1'b1;
                        end
                    end else if (bus.xfer_done) begin
                        r_int_pulse <= w_int;
                        r_desc_ptr  <= r_desc_ptr + DESC_AW'(8);
                    end
                end
                default: r_state <= ST_STOP;
            endcase

            // Descriptor boundary: END beats STOP, STOP beats the next fetch.
            if (w_complete) begin
                if (w_end) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_STOP;
                end else if (STOP) begin
                    r_paused <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_STOP;
                end else begin
                    r_state <= ST_FDS;
                end
            end
        end
    end
endmodule

// File: tb/tb_adma_desc_engine.sv
// Directed bench for adma_desc_engine: memory and data-mover responders plus per-scenario tasks.
module tb_adma_desc_engine;
    localparam logic [7:0] F_TRAN         = 8'h21;
    localparam logic [7:0] F_TRAN_END     = 8'h23;
    localparam logic [7:0] F_TRAN_END_INT = 8'h27;
    localparam logic [7:0] F_LINK         = 8'h31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_write;
    logic        cmd_continue;
    logic        stop;
    logic        dir;
    logic [31:0] start_addr;
    logic        busy, paused, done, error, int_pulse;
    logic [1:0]  err_state;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem [logic [31:0]];
    logic [31:0] fetch_q [$];
    logic [31:0] xaddr_q [$];
    logic [16:0] xlen_q  [$];
    logic        xdir_q  [$];
    logic        mem_hold = 1'b0;
    int          xr_cnt   = 0;
    logic        xr_seen  = 1'b0;
    int          int_cnt  = 0;
    logic        int_done_seen = 1'b0;

    adma_desc_engine_if #(.DESC_AW(32)) bus ();

    adma_desc_engine dut (
        .CLK                  (clk),
        .RESET                (rst_n),
        .command_reg_write    (cmd_write),
        .command_reg_continue (cmd_continue),
        .STOP                 (stop),
        .direction            (dir),
        .start_address        (start_addr),
        .bus                  (bus),
        .busy                 (busy),
        .paused               (paused),
        .done                 (done),
        .error                (error),
        .err_state            (err_state),
        .int_pulse            (int_pulse)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] mk_desc(input logic [31:0] a, input logic [15:0] l,
                                            input logic [7:0] f);
        return {a, l, 8'h00, f};
    endfunction

    // Memory: acks every request in the same cycle unless held off.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !mem_hold) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'd0;
                fetch_q.push_back(bus.mem_addr);
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
    end

    // Data mover: ready one cycle after valid appears, done three cycles after the handshake.
    initial begin
        bus.xfer_ready = 1'b0;
        bus.xfer_done  = 1'b0;
        forever begin
            @(negedge clk);
            bus.xfer_done = 1'b0;
            if (xr_cnt > 0) begin
                xr_cnt--;
                if (xr_cnt == 0) bus.xfer_done = 1'b1;
            end
            if (bus.xfer_ready) begin
                bus.xfer_ready = 1'b0;
            end else if (bus.xfer_valid) begin
                if (xr_seen) begin
                    xaddr_q.push_back(bus.xfer_addr);
                    xlen_q.push_back(bus.xfer_len);
                    xdir_q.push_back(bus.xfer_dir);
                    bus.xfer_ready = 1'b1;
                    xr_cnt  = 3;
                    xr_seen = 1'b0;
                end else begin
                    xr_seen = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (int_pulse) begin
            int_cnt++;
            int_done_seen = done;
        end
    end

    task automatic clear_logs();
        mem.delete();
        fetch_q.delete();
        xaddr_q.delete();
        xlen_q.delete();
        xdir_q.delete();
        int_cnt       = 0;
        int_done_seen = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic d);
        @(negedge clk);
        start_addr = a;
        dir        = d;
        cmd_write  = 1'b1;
        @(negedge clk);
        cmd_write  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.mem_req, bus.xfer_valid, busy, paused, done, error, int_pulse} !== 7'd0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000000",
                {bus.mem_req, bus.xfer_valid, busy, paused, done, error, int_pulse}); end
        checks++; if (err_state !== 2'b00) begin
            failures++; $display("FAIL reset_err_state got=%b exp=00", err_state); end
        checks++; if (bus.mem_addr !== 32'd0 || bus.xfer_len !== 17'd0 || bus.xfer_addr !== 32'd0) begin
            failures++; $display("FAIL reset_fields got=%h/%h/%h exp=0/0/0",
                bus.mem_addr, bus.xfer_len, bus.xfer_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_tran();
        int n_fetch;
        clear_logs();
        mem[32'h1000] = mk_desc(32'h8000, 16'h0200, F_TRAN_END_INT);
        start_cmd(32'h1000, 1'b1);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1000) begin
            failures++; $display("FAIL single_fetch got=%b/%h exp=1/00001000", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.xfer_valid !== 1'b0) begin
            failures++; $display("FAIL single_cadr_cycle got=%b exp=0", bus.xfer_valid); end
        @(negedge clk);
        checks++; if (bus.xfer_valid !== 1'b1 || bus.xfer_addr !== 32'h8000 ||
                      bus.xfer_len !== 17'h00200 || bus.xfer_dir !== 1'b1) begin
            failures++; $display("FAIL single_xfer got=%b/%h/%h/%b exp=1/00008000/00200/1",
                bus.xfer_valid, bus.xfer_addr, bus.xfer_len, bus.xfer_dir); end
        wait_idle(100, "single");
        checks++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            failures++; $display("FAIL single_status got=done%b busy%b err%b exp=1/0/0", done, busy, error); end
        checks++; if (int_cnt !== 1 || int_done_seen !== 1'b1) begin
            failures++; $display("FAIL single_int got=cnt%0d done%b exp=cnt1 done1", int_cnt, int_done_seen); end
        checks++; if (xaddr_q.size() !== 1) begin
            failures++; $display("FAIL single_xfer_count got=%0d exp=1", xaddr_q.size()); end
        n_fetch = fetch_q.size();
        @(negedge clk); cmd_continue = 1'b1;
        @(negedge clk); cmd_continue = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || fetch_q.size() !== n_fetch) begin
            failures++; $display("FAIL continue_ignored got=busy%b fetches%0d exp=busy0 fetches%0d",
                busy, fetch_q.size(), n_fetch); end
    endtask

    task automatic test_chain();
        clear_logs();
        mem[32'h1000] = mk_desc(32'h9000, 16'h0000, F_TRAN);
        mem[32'h1008] = mk_desc(32'h2000, 16'h0000, F_LINK);
        mem[32'h2000] = mk_desc(32'hA000, 16'h0010, F_TRAN_END);
        start_cmd(32'h1000, 1'b0);
        wait_idle(200, "chain");
        checks++; if (fetch_q.size() !== 3) begin
            failures++; $display("FAIL chain_fetch_count got=%0d exp=3", fetch_q.size());
        end else if (fetch_q[0] !== 32'h1000 || fetch_q[1] !== 32'h1008 || fetch_q[2] !== 32'h2000) begin
            failures++; $display("FAIL chain_fetch_addr got=%h,%h,%h exp=1000,1008,2000",
                fetch_q[0], fetch_q[1], fetch_q[2]); end
        checks++; if (xaddr_q.size() !== 2) begin
            failures++; $display("FAIL chain_xfer_count got=%0d exp=2", xaddr_q.size());
        end else if (xlen_q[0] !== 17'h10000 || xaddr_q[0] !== 32'h9000 || xdir_q[0] !== 1'b0) begin
            failures++; $display("FAIL chain_xfer0 got=%h/%h/%b exp=10000/00009000/0",
                xlen_q[0], xaddr_q[0], xdir_q[0]);
        end else if (xlen_q[1] !== 17'h00010 || xaddr_q[1] !== 32'hA000) begin
            failures++; $display("FAIL chain_xfer1 got=%h/%h exp=00010/0000a000", xlen_q[1], xaddr_q[1]); end
        checks++; if (done !== 1'b1 || error !== 1'b0 || int_cnt !== 0) begin
            failures++; $display("FAIL chain_status got=done%b err%b int%0d exp=1/0/0", done, error, int_cnt); end
    endtask

    task automatic test_invalid();
        clear_logs();
        mem[32'h1000] = mk_desc(32'h8000, 16'h0004, F_TRAN);
        mem[32'h1008] = 64'd0;
        start_cmd(32'h1000, 1'b1);
        wait_idle(200, "invalid");
        checks++; if (error !== 1'b1 || err_state !== 2'b10 || done !== 1'b0) begin
            failures++; $display("FAIL invalid_status got=err%b st%b done%b exp=1/10/0", error, err_state, done); end
        checks++; if (xaddr_q.size() !== 1 || fetch_q.size() !== 2) begin
            failures++; $display("FAIL invalid_counts got=xfer%0d fetch%0d exp=1/2", xaddr_q.size(), fetch_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL invalid_sticky got=err%b busy%b exp=1/0", error, busy); end
    endtask

    task automatic test_misaligned();
        clear_logs();
        mem[32'h1000] = mk_desc(32'h8002, 16'h0010, F_TRAN_END);
        start_cmd(32'h1000, 1'b0);
        wait_idle(100, "tran_align");
        checks++; if (error !== 1'b1 || err_state !== 2'b10 || xaddr_q.size() !== 0) begin
            failures++; $display("FAIL tran_align got=err%b st%b xfer%0d exp=1/10/0", error, err_state, xaddr_q.size()); end
        clear_logs();
        mem[32'h1000] = mk_desc(32'h2004, 16'h0000, F_LINK);
        start_cmd(32'h1000, 1'b0);
        wait_idle(100, "link_align");
        checks++; if (error !== 1'b1 || fetch_q.size() !== 1) begin
            failures++; $display("FAIL link_align got=err%b fetch%0d exp=1/1", error, fetch_q.size()); end
        clear_logs();
        mem[32'h1000] = mk_desc(32'h8004, 16'h0010, F_TRAN_END);
        start_cmd(32'h1000, 1'b0);
        wait_idle(100, "restart");
        checks++; if (error !== 1'b0 || done !== 1'b1 || err_state !== 2'b00) begin
            failures++; $display("FAIL restart_clears got=err%b done%b st%b exp=0/1/00", error, done, err_state); end
    endtask

    task automatic test_stop_pause();
        clear_logs();
        mem[32'h1000] = mk_desc(32'h8000, 16'h0040, F_TRAN);
        mem[32'h1008] = mk_desc(32'h8800, 16'h0080, F_TRAN_END);
        stop = 1'b1;
        start_cmd(32'h1000, 1'b1);
        wait_idle(200, "pause");
        checks++; if (paused !== 1'b1 || done !== 1'b0 || fetch_q.size() !== 1 || xaddr_q.size() !== 1) begin
            failures++; $display("FAIL pause_state got=p%b d%b fetch%0d xfer%0d exp=1/0/1/1",
                paused, done, fetch_q.size(), xaddr_q.size()); end
        stop = 1'b0;
        @(negedge clk); cmd_continue = 1'b1;
        @(negedge clk); cmd_continue = 1'b0;
        checks++; if (paused !== 1'b0 || busy !== 1'b1 || bus.mem_addr !== 32'h1008) begin
            failures++; $display("FAIL resume got=p%b b%b addr%h exp=0/1/00001008", paused, busy, bus.mem_addr); end
        wait_idle(200, "resume");
        checks++; if (fetch_q.size() !== 2 || done !== 1'b1 || xaddr_q.size() !== 2) begin
            failures++; $display("FAIL resume_end got=fetch%0d d%b xfer%0d exp=2/1/2", fetch_q.size(), done, xaddr_q.size());
        end else if (fetch_q[1] !== 32'h1008 || xaddr_q[1] !== 32'h8800) begin
            failures++; $display("FAIL resume_addr got=%h/%h exp=00001008/00008800", fetch_q[1], xaddr_q[1]); end
    endtask

    task automatic test_reset_abort();
        clear_logs();
        mem_hold = 1'b1;
        start_cmd(32'h1000, 1'b1);
        checks++; if (bus.mem_req !== 1'b1) begin
            failures++; $display("FAIL abort_pre got=%b exp=1", bus.mem_req); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_req, bus.xfer_valid, busy, done, error, paused} !== 6'd0) begin
            failures++; $display("FAIL abort_async got=%b exp=000000",
                {bus.mem_req, bus.xfer_valid, busy, done, error, paused}); end
        @(negedge clk);
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        clear_logs();
        mem[32'h1000] = mk_desc(32'h8000, 16'h0200, F_TRAN_END_INT);
        start_cmd(32'h1000, 1'b1);
        wait_idle(100, "after_abort");
        checks++; if (done !== 1'b1 || xaddr_q.size() !== 1 || int_cnt !== 1) begin
            failures++; $display("FAIL after_abort got=d%b xfer%0d int%0d exp=1/1/1", done, xaddr_q.size(), int_cnt); end
    endtask

    task automatic test_link_loop();
        bit same;
        clear_logs();
        mem[32'h3000] = mk_desc(32'h3000, 16'h0000, F_LINK);
        start_cmd(32'h3000, 1'b0);
`ifdef ADMA_LINK_GUARD_EN
        wait_idle(400, "loop_guard");
        checks++; if (error !== 1'b1 || err_state !== 2'b10 || fetch_q.size() !== 16) begin
            failures++; $display("FAIL loop_guard got=err%b st%b fetch%0d exp=1/10/16", error, err_state, fetch_q.size()); end
`else
        repeat (120) @(negedge clk);
        checks++; if (busy !== 1'b1 || error !== 1'b0 || fetch_q.size() <= 16) begin
            failures++; $display("FAIL loop_free got=b%b err%b fetch%0d exp=1/0/>16", busy, error, fetch_q.size()); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        same = 1'b1;
        foreach (fetch_q[i]) if (fetch_q[i] !== 32'h3000) same = 1'b0;
        checks++; if (!same) begin
            failures++; $display("FAIL loop_addr got=non-3000 fetch exp=all 00003000"); end
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_write    = 1'b0;
        cmd_continue = 1'b0;
        stop         = 1'b0;
        dir          = 1'b0;
        start_addr   = 32'd0;
        test_reset();
        test_single_tran();
        test_chain();
        test_invalid();
        test_misaligned();
        test_stop_pause();
        test_reset_abort();
        test_link_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adma_desc_engine.md
# adma_desc_engine

Descriptor-processing stage of the SD host ADMA2 path, sitting directly downstream of the DMA command signals (`command_reg_write`, `command_reg_continue`, `STOP`, `direction`). It walks a 64-bit ADMA2 descriptor table in system memory through a simple read handshake. It issues one transfer command per TRAN descriptor to the downstream data mover and reports done, error and interrupt status to the host register block.

## Interface
- `DESC_AW`, 32: descriptor and data address width.
- `LINK_GUARD_MAX`, 16: consecutive LINK/NOP descriptors allowed before a loop error (only with the guard macro).

- `CLK` in 1: single clock; all logic on the rising edge.
- `RESET` in 1: asynchronous, active-low.
- `command_reg_write` in 1: start pulse; loads `start_address`.
- `command_reg_continue` in 1: resume pulse after a STOP pause.
- `STOP` in 1: level; requests a pause at the next descriptor boundary.
- `direction` in 1: 1 = host-to-card (write), 0 = card-to-host; latched at start.
- `start_address` in DESC_AW: first descriptor address.
- `mem_req`/`mem_addr` out 1/DESC_AW: descriptor read request and address.
- `mem_ack`/`mem_rdata` in 1/64: read completion and descriptor word.
- `xfer_valid`/`xfer_ready` out/in 1: transfer command handshake.
- `xfer_addr`/`xfer_len`/`xfer_dir` out DESC_AW/17/1: transfer command fields.
- `xfer_done` in 1: data mover finished the current command.
- `busy`/`paused`/`done`/`error` out 1: status.
- `err_state` out 2: state at error (00 STOP, 01 FDS, 10 CADR, 11 TFR).
- `int_pulse` out 1: one-cycle pulse when a descriptor with INT=1 completes.

## Operation
- Descriptor word layout: [0] VALID, [1] END, [2] INT, [5:4] ACT (00 NOP, 01 RSV, 10 TRAN, 11 LINK), [31:16] LENGTH, [63:32] ADDRESS.
- States:
  - ST_STOP (idle/paused).
  - ST_FDS (fetch descriptor).
  - ST_CADR (decode/change address).
  - ST_TFR (transfer).
- ST_STOP:
  - `command_reg_write` latches `start_address` into `desc_ptr` and `direction`, clears done/error/paused, sets busy, goes to FDS.
  - `command_reg_continue` with paused=1 clears paused, goes to FDS at the unchanged `desc_ptr`.
  - If both pulses are high in the same cycle, write wins.
  - Either pulse outside ST_STOP is ignored.
- ST_FDS:
  - `mem_req`=1 with `mem_addr`=`desc_ptr`, held until `mem_ack`.
  - `mem_rdata` is captured on the ack cycle; next state is CADR.
- ST_CADR (one cycle), by priority:
  - VALID=0 → error.
  - LINK with ADDRESS[2:0]≠0, or TRAN with ADDRESS[1:0]≠0 → error.
  - TRAN → TFR.
  - LINK → `desc_ptr`=ADDRESS.
  - NOP/RSV → `desc_ptr`+=8.
- ST_TFR:
  - Drive `xfer_valid` with the descriptor fields until `xfer_ready`, then wait for `xfer_done`.
  - On `xfer_done`: pulse `int_pulse` if INT=1, then `desc_ptr`+=8.
- Descriptor completion, after CADR (non-TRAN) or after `xfer_done` (TRAN):
  - END=1 → done=1, busy=0, ST_STOP.
  - Otherwise, STOP=1 → paused=1, busy=0, ST_STOP.
  - Otherwise → FDS.
- Error: error=1, err_state=current-state code, busy=0, ST_STOP. error is sticky until the next `command_reg_write`; done is sticky likewise.
- LENGTH=0 encodes 65536: `xfer_len`=17'h10000; otherwise `xfer_len`={1'b0,LENGTH}.
- `desc_ptr` increments wrap modulo 2^DESC_AW.
- `RESET` low at any time aborts immediately: pending `mem_req`/`xfer_valid` drop to 0 asynchronously.

## Timing
- Reset values: every output 0; state ST_STOP; `desc_ptr` 0.
- `command_reg_write` sampled in cycle 0 → `mem_req` high in cycle 1.
- `mem_ack` in cycle N → CADR in N+1 → `xfer_valid` or next `mem_req` in N+2.
- `xfer_valid` and its fields stay stable until the cycle `xfer_ready`=1 (inclusive); they drop the following cycle.
- `xfer_done` is ignored until the command handshake has completed.
- `int_pulse` is asserted in the cycle after `xfer_done`; done/paused update in that same cycle.
- `STOP` is sampled only at descriptor completion. It never interrupts an outstanding read or transfer.

## Configuration
- `ADMA_LINK_GUARD_EN`:
  - Defined: a counter of consecutive non-TRAN descriptors resets on each TRAN. Reaching `LINK_GUARD_MAX` raises error with err_state=10.
  - Undefined: no counter, and infinite LINK loops are possible.

## Test plan
- Single TRAN at 0x1000 (ADDR 0x8000, LEN 0x0200, END=1, INT=1) → `mem_addr`=0x1000; `xfer_addr`=0x8000, `xfer_len`=0x200; `int_pulse` one cycle; done=1, busy=0.
- TRAN (LEN 0) → LINK to 0x2000 → TRAN END at 0x2000 → fetches at 0x1000, 0x1008, 0x2000; first `xfer_len`=0x10000; done after the second transfer.
- Descriptor with VALID=0 at the second entry → error=1, err_state=10, no second `xfer_valid`.
- `STOP` held during the first of two TRANs → paused=1 after `xfer_done`, no fetch; `command_reg_continue` → fetch at 0x1008.
- `RESET` low while `mem_req`=1 → all outputs 0 at once; a subsequent start works normally.
- With `ADMA_LINK_GUARD_EN`, a LINK pointing to itself → error after 16 fetches; without the macro → fetches continue indefinitely.
